popcnt_frame_accum: RTL and testbench



---
 rtl/popacc_pkg.sv | 17 +
 rtl/popcnt7_tree.sv | 25 ++
 rtl/popcnt_frame_accum.sv | 149 ++++++++++++++
 tb/tb_popcnt_frame_accum.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/popacc_pkg.sv
// Shared types and constants for the frame popcount accumulator.
package popacc_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CNT_W = 3;

    // Narrowest accumulator that can hold a full frame of all-ones words.
    function automatic int min_sum_w(input int words);
        return $clog2(7 * words + 1);
    endfunction

endpackage

// File: rtl/popcnt7_tree.sv
// Combinational 7:3 counter: four full adders, three for the weight-1
// column and one compressing the three weight-2 carries.
module popcnt7_tree
    import popacc_pkg::*;
(
    input  logic [6:0]       i_bits,
    output logic [CNT_W-1:0] o_count
);

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    logic [1:0] w_fa0;
    logic [1:0] w_fa1;
    logic [1:0] w_fa2;
    logic [1:0] w_fa3;

    assign w_fa0   = full_add(i_bits[0], i_bits[1], i_bits[2]);
    assign w_fa1   = full_add(i_bits[3], i_bits[4], i_bits[5]);
    assign w_fa2   = full_add(w_fa0[0], w_fa1[0], i_bits[6]);
    assign w_fa3   = full_add(w_fa0[1], w_fa1[1], w_fa2[1]);
    assign o_count = {w_fa3[1], w_fa3[0], w_fa2[0]};

endmodule

// File: rtl/popcnt_frame_accum.sv
// Frame-level popcount accumulator. Define POPACC_THRESH_EN to add the
// thresh input and the registered out_over comparison flag.
module popcnt_frame_accum
    import popacc_pkg::*;
#(
    parameter int WORDS_PER_FRAME = 16,
    parameter int SUM_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef POPACC_THRESH_EN
    input  logic [SUM_W-1:0] thresh,
    output logic             out_over,
`endif
    output logic [SUM_W-1:0] out_sum
);

    localparam int WCNT_W = $clog2(WORDS_PER_FRAME);
    localparam logic [WCNT_W-1:0] LAST_WCNT = WCNT_W'(WORDS_PER_FRAME - 1);

    generate
        if (WORDS_PER_FRAME < 2) begin : g_bad_words
            $error("popcnt_frame_accum: WORDS_PER_FRAME must be at least 2");
        end
        if (SUM_W < min_sum_w(WORDS_PER_FRAME)) begin : g_bad_sum_w
            $error("popcnt_frame_accum: SUM_W too narrow for WORDS_PER_FRAME");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_next;
    logic [WCNT_W-1:0]  r_wcnt;
    logic               r_s1_valid;
    logic [CNT_W-1:0]   r_s1_cnt;
    logic [CNT_W-1:0]   w_cnt;
    logic [SUM_W-1:0]   r_sum;
    logic [SUM_W-1:0]   w_sum_add;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_last_word;

    popcnt7_tree u_tree (
        .i_bits  (in_data),
        .o_count (w_cnt)
    );

    // Handshake strobes are pure decodes of the state register.
    assign in_ready    = (r_state == ACCUM);
    assign out_valid   = (r_state == DONE);
    assign w_in_fire   = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign w_last_word = (r_wcnt == LAST_WCNT);
    assign w_sum_add   = r_s1_valid ? (r_sum + {{(SUM_W-CNT_W){1'b0}}, r_s1_cnt}) : r_sum;
    assign out_sum     = r_sum;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM: begin
                if (w_in_fire && w_last_word) begin
                    w_state_next = DRAIN;
                end else begin
                    w_state_next = ACCUM;
                end
            end
            DRAIN: begin
                w_state_next = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = ACCUM;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: begin
                w_state_next = ACCUM;
            end
        endcase
    end

    // Word counter within the current frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= {WCNT_W{1'b0}};
        end else if (w_in_fire) begin
            r_wcnt <= w_last_word ? {WCNT_W{1'b0}} : (r_wcnt + WCNT_W'(1));
        end else begin
            r_wcnt <= r_wcnt;
        end
    end

    // Stage 1: registered per-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cnt   <= {CNT_W{1'b0}};
        end else begin
            r_s1_valid <= w_in_fire;
            r_s1_cnt   <= w_in_fire ? w_cnt : r_s1_cnt;
        end
    end

    // Stage 2: frame accumulator, cleared when the total is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= {SUM_W{1'b0}};
        end else if (w_out_fire) begin
            r_sum <= {SUM_W{1'b0}};
        end else begin
            r_sum <= w_sum_add;
        end
    end

`ifdef POPACC_THRESH_EN
    logic r_over;

    // The DRAIN edge is where the final add lands, so compare the incoming sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_over <= 1'b0;
        end else if (w_out_fire) begin
            r_over <= 1'b0;
        end else if (r_state == DRAIN) begin
            r_over <= (w_sum_add > thresh);
        end else begin
            r_over <= r_over;
        end
    end

    assign out_over = r_over;
`endif

endmodule

// File: tb/tb_popcnt_frame_accum.sv
// Directed bench for popcnt_frame_accum; define POPACC_THRESH_EN to also
// exercise the threshold flag.
module tb_popcnt_frame_accum;

    localparam int WPF = 16;
    localparam int SW  = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SW-1:0] out_sum;
`ifdef POPACC_THRESH_EN
    logic [SW-1:0] thresh;
    logic          out_over;
`endif

    int cyc      = 0;
    int n_vec    = 0;
    int n_err    = 0;
    int last_acc = 0;
    int first_acc;
    int exp_sum;
    logic [6:0] rnd;

    popcnt_frame_accum #(.WORDS_PER_FRAME(WPF), .SUM_W(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef POPACC_THRESH_EN
        .thresh    (thresh),
        .out_over  (out_over),
`endif
        .out_sum   (out_sum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Present one word and hold it until the edge where in_ready is high.
    task automatic push(input logic [6:0] d);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 40 && !done; k++) begin
            if (in_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        last_acc = cyc;
        check_eq("push_accept", 32'(done), 32'd1);
    endtask

    task automatic push_n(input logic [6:0] d, input int n);
        for (int k = 0; k < n; k++) push(d);
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    endtask

    task automatic take_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_cleared"}, 32'(out_sum), 32'd0);
        check_eq({tag, "_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 7'd0;
        out_ready = 1'b0;
`ifdef POPACC_THRESH_EN
        thresh    = 8'd100;
`endif
        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
`ifdef POPACC_THRESH_EN
        check_eq("rst_out_over", 32'(out_over), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Frame of all-ones words, no backpressure: latency and period.
        out_ready = 1'b1;
        for (int i = 0; i < WPF; i++) begin
            push(7'h7F);
            if (i == 0) first_acc = last_acc;
        end
        check_eq("t1_drain_valid", 32'(out_valid), 32'd0);
        check_eq("t1_drain_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("t1_latency", 32'(cyc - last_acc), 32'd1);
        check_eq("t1_done_valid", 32'(out_valid), 32'd1);
        check_eq("t1_sum", 32'(out_sum), 32'd112);
`ifdef POPACC_THRESH_EN
        check_eq("t1_over", 32'(out_over), 32'd1);
`endif
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("t1_hs_valid", 32'(out_valid), 32'd0);
        check_eq("t1_hs_ready", 32'(in_ready), 32'd1);
        check_eq("t1_hs_sum", 32'(out_sum), 32'd0);
`ifdef POPACC_THRESH_EN
        check_eq("t1_hs_over", 32'(out_over), 32'd0);
`endif

        // Alternating 00/55 words, then a frame of 01 to confirm the clear.
        for (int i = 0; i < WPF / 2; i++) begin
            push(7'h00);
            if (i == 0) check_eq("t1_period", 32'(last_acc - first_acc), 32'd18);
            push(7'h55);
        end
        wait_done("t2a");
        check_eq("t2a_sum", 32'(out_sum), 32'd32);
        take_out("t2a");
        push_n(7'h01, WPF);
        wait_done("t2b");
        check_eq("t2b_sum", 32'(out_sum), 32'd16);
        take_out("t2b");

        // Backpressure in DONE; in_valid driven with junk must be ignored.
        push_n(7'h07, WPF);
        wait_done("t3");
        in_valid = 1'b1;
        in_data  = 7'h7F;
        for (int k = 0; k < 5; k++) begin
            check_eq("t3_stall_ready", 32'(in_ready), 32'd0);
            check_eq("t3_stall_valid", 32'(out_valid), 32'd1);
            check_eq("t3_stall_sum", 32'(out_sum), 32'd48);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        take_out("t3");
        check_eq("t3_hs_valid", 32'(out_valid), 32'd0);

        // Random data with random bubbles carrying garbage data.
        exp_sum = 0;
        for (int i = 0; i < WPF; i++) begin
            if ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                in_data  = 7'($urandom);
                @(posedge clk);
                #1;
            end
            rnd = 7'($urandom);
            exp_sum += $countones(rnd);
            push(rnd);
        end
        wait_done("t4");
        check_eq("t4_sum", 32'(out_sum), 32'(exp_sum));
        take_out("t4");

        // Reset in the middle of a frame discards the partial frame.
        push_n(7'h7F, 5);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_ready", 32'(in_ready), 32'd1);
        check_eq("t5_rst_valid", 32'(out_valid), 32'd0);
        check_eq("t5_rst_sum", 32'(out_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_n(7'h03, WPF);
        wait_done("t5");
        check_eq("t5_sum", 32'(out_sum), 32'd32);
        take_out("t5");

`ifdef POPACC_THRESH_EN
        // 96 is not above 100.
        push_n(7'h3F, WPF);
        wait_done("t6");
        check_eq("t6_sum", 32'(out_sum), 32'd96);
        check_eq("t6_over", 32'(out_over), 32'd0);
        take_out("t6");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
